// File: rtl/cskip_pkg.sv
// Shared helpers for the pipelined carry-skip adder: sizing functions and
// parameter legality predicates used at elaboration time.
package cskip_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int num_stg(input int width, input int blk, input int blks_per_stage);
        return (width / blk) / blks_per_stage;
    endfunction

    function automatic bit width_ok(input int width, input int blk);
        return (blk > 0) && (width > 0) && (width % blk == 0);
    endfunction

    function automatic bit stage_ok(input int width, input int blk, input int blks_per_stage);
        return (blks_per_stage > 0) && ((width / blk) % blks_per_stage == 0);
    endfunction

endpackage

// File: rtl/cskip_block.sv
// One carry-skip block: BLK-bit ripple adder whose carry-out bypasses the
// ripple chain through a mux whenever every bit propagates.
module cskip_block
    import cskip_pkg::*;
#(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           ci,
    output logic [BLK-1:0] s,
    output logic           co,
    output logic           cmsb
);

    logic [BLK-1:0] p;
    logic [BLK-1:0] g;
    logic [BLK-1:0] c;
    logic [BLK:0]   k0;
    logic           all_p;

    assign p     = a ^ b;
    assign g     = a & b;
    assign all_p = &p;

    // The carry-out chain starts from 0: when the block does not fully
    // propagate its carry-out is independent of ci, so ci reaches co only via the mux.
    always_comb begin
        // NOTE: defaults first so every bit is assigned on every pass (no latch).
        c     = '0;
        k0    = '0;
        c[0]  = ci;
        k0[0] = 1'b0;
        for (int i = 1; i < BLK; i++) begin
            c[i] = g[i-1] | (p[i-1] & c[i-1]);
        end
        for (int i = 0; i < BLK; i++) begin
            k0[i+1] = g[i] | (p[i] & k0[i]);
        end
    end

    assign s    = p ^ c;
    assign co   = all_p ? ci : k0[BLK];
    assign cmsb = c[BLK-1];

endmodule

// File: rtl/cskip_adder_pipe.sv
// Pipelined carry-skip adder with valid/ready on both sides.
// Optional subtract mode is enabled by defining CSKIP_SUB_EN.
module cskip_adder_pipe
    import cskip_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BLK            = 4,
    parameter int BLKS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CSKIP_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NUM_STG = num_stg(WIDTH, BLK, BLKS_PER_STAGE);
    localparam int SW      = BLK * BLKS_PER_STAGE;
    localparam int LAST    = NUM_STG - 1;

    if (!width_ok(WIDTH, BLK)) begin : g_chk_width
        $error("cskip_adder_pipe: WIDTH must be a positive multiple of BLK");
    end
    if (!stage_ok(WIDTH, BLK, BLKS_PER_STAGE)) begin : g_chk_stage
        $error("cskip_adder_pipe: WIDTH/BLK must be a multiple of BLKS_PER_STAGE");
    end

    logic             advance;
    logic             c0;
    logic [WIDTH-1:0] b_eff;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

`ifdef CSKIP_SUB_EN
    assign b_eff = sub ? ~b : b;
    assign c0    = sub | cin;
`else
    assign b_eff = b;
    assign c0    = cin;
`endif

    for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
        localparam int RW = WIDTH - k * SW;  // operand bits not yet summed

        logic              v_in;
        logic              c_in;
        logic [RW-1:0]     a_in;
        logic [RW-1:0]     b_in;
        logic [SW-1:0]     s_blk;
        logic              cmsb_w [BLKS_PER_STAGE];
        logic              v_q;
        logic              c_q;
        logic [(k+1)*SW-1:0] s_q;
        logic [(k+1)*SW-1:0] s_d;

        if (k == 0) begin : g_src
            assign v_in = in_valid;
            assign a_in = a;
            assign b_in = b_eff;
            assign c_in = c0;
            assign s_d  = s_blk;
        end else begin : g_src
            assign v_in = g_stg[k-1].v_q;
            assign a_in = g_stg[k-1].g_ops.a_q;
            assign b_in = g_stg[k-1].g_ops.b_q;
            assign c_in = g_stg[k-1].c_q;
            assign s_d  = {s_blk, g_stg[k-1].s_q};
        end

        for (genvar j = 0; j < BLKS_PER_STAGE; j++) begin : g_blk
            logic ci_w;
            logic co_w;

            if (j == 0) begin : g_ci
                assign ci_w = c_in;
            end else begin : g_ci
                assign ci_w = g_blk[j-1].co_w;
            end

            cskip_block #(.BLK(BLK)) u_blk (
                .a    (a_in[j*BLK +: BLK]),
                .b    (b_in[j*BLK +: BLK]),
                .ci   (ci_w),
                .s    (s_blk[j*BLK +: BLK]),
                .co   (co_w),
                .cmsb (cmsb_w[j])
            );
        end

        // NOTE: data registers are reset as well, so sum/cout/ovf read 0 out of reset.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (advance) begin
                // NOTE: non-blocking so every stage samples its predecessor's old value.
                v_q <= v_in;
                c_q <= g_blk[BLKS_PER_STAGE-1].co_w;
                s_q <= s_d;
            end
        end

        if (k < LAST) begin : g_ops
            logic [RW-SW-1:0] a_q;
            logic [RW-SW-1:0] b_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[RW-1:SW];
                    b_q <= b_in[RW-1:SW];
                end
            end
        end else begin : g_msb
            logic cm_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cm_q <= 1'b0;
                end else if (advance) begin
                    cm_q <= cmsb_w[BLKS_PER_STAGE-1];
                end
            end
        end
    end

    assign out_valid = g_stg[LAST].v_q;
    assign sum       = g_stg[LAST].s_q;
    assign cout      = g_stg[LAST].c_q;
    assign ovf       = g_stg[LAST].g_msb.cm_q ^ g_stg[LAST].c_q;

endmodule

// File: tb/tb_cskip_adder_pipe.sv
// Self-checking bench for cskip_adder_pipe at default parameters (2 stages).
// Directed table, back-pressure, mid-stream reset and a random streaming run.
module tb_cskip_adder_pipe;

    localparam int W     = 16;
    localparam int NRAND = 10000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef CSKIP_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cskip_adder_pipe #(.WIDTH(16), .BLK(4), .BLKS_PER_STAGE(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CSKIP_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    function automatic vec_t mkv(input logic [15:0] x, input logic [15:0] y, input logic ci,
                                 input logic sb, input logic [15:0] s, input logic co,
                                 input logic ov);
        vec_t v;
        v.a = x; v.b = y; v.cin = ci; v.sub = sb; v.sum = s; v.cout = co; v.ovf = ov;
        return v;
    endfunction

    // Reference: {cout, ovf, sum}; ovf = carry into bit 15 XOR carry out.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        logic [15:0] yy;
        logic        cc;
        logic [16:0] t;
        logic [15:0] lo;
        yy = sb ? ~y : y;
        cc = sb ? 1'b1 : ci;
        t  = {1'b0, x} + {1'b0, yy} + {16'b0, cc};
        lo = {1'b0, x[14:0]} + {1'b0, yy[14:0]} + {15'b0, cc};
        return {t[16], t[16] ^ lo[15], t[15:0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic ci,
                         input logic sb);
        a   = x;
        b   = y;
        cin = ci;
`ifdef CSKIP_SUB_EN
        sub = sb;
`else
        if (sb) $display("note: subtract vector skipped in add-only build");
`endif
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        drive(v.a, v.b, v.cin, v.sub);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 check($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check($sformatf("v%0d_valid_t1", idx), 32'(out_valid), 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_valid_t2", idx), 32'(out_valid), 32'd1);
        check($sformatf("v%0d_sum", idx), 32'(sum), 32'(v.sum));
        check($sformatf("v%0d_cout", idx), 32'(cout), 32'(v.cout));
        check($sformatf("v%0d_ovf", idx), 32'(ovf), 32'(v.ovf));
    endtask

    initial begin
        vec_t        vecs[$];
        logic [15:0] bp_exp [3];
        logic [17:0] exp_q[$];
        logic [17:0] e;
        logic [18:0] prev_word;
        logic        prev_stall;
        logic        sb_r;
        int          got;
        int          sent;
        int          cycles;
        bit          found;

        vecs.push_back(mkv(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mkv(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));
        vecs.push_back(mkv(16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mkv(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mkv(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1));
        vecs.push_back(mkv(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0));
        vecs.push_back(mkv(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0));
        vecs.push_back(mkv(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mkv(16'h5555, 16'hAAAA, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0));
        vecs.push_back(mkv(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0));
        vecs.push_back(mkv(16'h7000, 16'h1000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));
`ifdef CSKIP_SUB_EN
        vecs.push_back(mkv(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0));
        vecs.push_back(mkv(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1));
        vecs.push_back(mkv(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0));
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(16'h0, 16'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Back-pressure: three transfers, consumer stalls from first result.
        bp_exp[0] = 16'h0002; bp_exp[1] = 16'h0004; bp_exp[2] = 16'h0006;
        @(negedge clk);
        drive(16'h0001, 16'h0001, 1'b0, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        drive(16'h0002, 16'h0002, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_first_valid", 32'(out_valid), 32'd1);
        check("bp_first_sum", 32'(sum), 32'h0002);
        out_ready = 1'b0;
        drive(16'h0003, 16'h0003, 1'b0, 1'b0);
        #1 check("bp_in_ready_stall0", 32'(in_ready), 32'd0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("bp_in_ready_stall%0d", i), 32'(in_ready), 32'd0);
            check($sformatf("bp_valid_stall%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_sum_hold%0d", i), 32'(sum), 32'h0002);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 check("bp_in_ready_release", 32'(in_ready), 32'd1);
        check("bp_res0", 32'(sum), 32'(bp_exp[0]));
        got = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                if (got < 3) check($sformatf("bp_res%0d", got), 32'(sum), 32'(bp_exp[got]));
                got++;
            end
        end
        check("bp_result_count", 32'(got), 32'd3);
        check("bp_drained", 32'(out_valid), 32'd0);

        // Reset with two results in flight.
        @(negedge clk);
        drive(16'h0005, 16'h0005, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        drive(16'h0006, 16'h0006, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_sum", 32'(sum), 32'd0);
        check("mrst_cout", 32'(cout), 32'd0);
        check("mrst_ovf", 32'(ovf), 32'd0);
        drive(16'h0007, 16'h0008, 1'b0, 1'b0);
        in_valid = 1'b1;
        #1 check("mrst_in_ready", 32'(in_ready), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid && !found) begin
                found = 1'b1;
                check("mrst_first_result", 32'(sum), 32'h000F);
            end
        end
        check("mrst_result_seen", 32'(found), 32'd1);

        // Random streaming run with random back-pressure.
        sent       = 0;
        cycles     = 0;
        prev_stall = 1'b0;
        prev_word  = '0;
        while ((sent < NRAND || exp_q.size() > 0) && cycles < 60000) begin
            @(negedge clk);
            cycles++;
            if (prev_stall) check("rand_hold", 32'({out_valid, cout, ovf, sum}), 32'(prev_word));
            out_ready = ($urandom_range(0, 3) != 0);
            sb_r      = 1'b0;
            if (sent < NRAND) begin
                in_valid = ($urandom_range(0, 4) != 0);
`ifdef CSKIP_SUB_EN
                sb_r = 1'($urandom_range(0, 1));
`endif
                drive(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), sb_r);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rand_result", 32'({cout, ovf, sum}), 32'(e));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sb_r));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_valid, cout, ovf, sum};
        end
        check("rand_all_sent", 32'(sent), 32'(NRAND));
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
